uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. rx is double-flopped into the clk domain.
//                A falling edge of the synchronised line starts a frame.
//                Each bit is sampled once, near the middle of its bit period:
//                start bit, data_width data bits LSB first, an optional
//                even-parity bit, then the stop bit. The block returns to
//                idle right after the stop sample, so back-to-back frames
//                need no idle gap.
//  Optional    : define UART_RX_PARITY_EN to add the parity bit, the PARITY
//                state and the parity_err port.
//  Parameters  : data_width   - data bits per frame (5..9)
//                clks_per_bit - clk cycles per bit period (even, >= 4)
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                rx_en      - enables start-bit detection only
//                rx         - asynchronous serial input, idle high
//                data       - last received word, held until the next done
//                done       - one-cycle pulse at the stop-bit sample
//                busy       - high while a frame is in progress
//                frame_err  - stop bit of the last frame was sampled low
//                parity_err - parity of the last frame was wrong (option)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int data_width   = 8,
  parameter int clks_per_bit = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  rx,
  output logic [data_width-1:0] data,
  output logic                  done,
  output logic                  busy,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  frame_err
);

  localparam int CNT_W = (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  localparam int IDX_W = (data_width > 2) ? $clog2(data_width) : 1;

  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(clks_per_bit / 2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(clks_per_bit - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(data_width - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  // Synchroniser and edge-detect history; all reset to the idle (high) level
  // so that a reset never manufactures a falling edge.
  logic r_sync1;
  logic r_sync2;
  logic r_rx_prev;
  logic w_rx_s;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= w_rx_s;
    end
  end

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [data_width-1:0] r_shift;
  logic [data_width-1:0] r_data;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_bit;
  logic                  r_parity_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Requires a real high-to-low transition, so a line stuck low
          // after a framing error cannot retrigger reception.
          if (rx_en && r_rx_prev && !w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == c_cnt_half) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              // Line is high again at mid start bit: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[data_width-1:1]};
            if (r_idx == c_idx_last) begin
              r_idx   <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          // Results are published at the stop sample and the FSM goes idle
          // immediately; the rest of the stop bit overlaps idle time.
          if (r_cnt == c_cnt_last) begin
            r_cnt        <= '0;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_data       <= r_shift;
            r_frame_err  <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign done       = r_done;
  assign busy       = r_busy;
  assign frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are built from
//                plain bit lists; every frame the receiver should report is
//                queued with its expected word and error flags, and each
//                done pulse is matched against the head of that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          rx_en = 1'b0;
  logic          rx    = 1'b1;
  logic [DW-1:0] data;
  logic          done;
  logic          busy;
  logic          frame_err;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .data_width   (DW),
    .clks_per_bit (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx         (rx),
    .data       (data),
    .done       (done),
    .busy       (busy),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned cyc_fall = 0;
  int          last_lat = 0;
  int          n_done   = 0;
  int          viol     = 0;
  bit          hold_en  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every done pulse must match the oldest outstanding frame.
  initial begin : monitor
    logic          prev_done;
    logic [DW-1:0] prev_data;
    exp_t          e;
    prev_done = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        last_lat = int'(cyc - cyc_fall);
        check_eq("frame_pending_at_done", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("data", 32'(data), 32'(e.d));
          check_eq("frame_err", 32'(frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
          check_eq("parity_err", 32'(parity_err), 32'(e.perr));
`endif
        end
        check_eq("busy_in_done_cycle", 32'(busy), 32'd0);
      end
      if (hold_en && !done && (data !== prev_data)) viol++;
      if (done && prev_done) viol++;
      prev_done = done;
      prev_data = data;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame starting at the current negedge. The expected record is
  // derived from the frame contents: frame error = stop bit low, parity error
  // = odd number of ones over data plus parity bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b,
                            input logic par_b, input bit drop_en, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.d    = d;
      e.ferr = ~stop_b;
      e.perr = (^d) ^ par_b;
      exp_q.push_back(e);
    end
    cyc_fall = cyc;
    drive_bit(1'b0);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
    if (drop_en) rx_en = 1'b1;
  endtask

  initial begin : stim
    int            base;
    logic [DW-1:0] d;
    logic          stop_b;
    logic          par_b;
    int            waited;

    repeat (3) @(negedge clk);
    check_eq("reset_data", 32'(data), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_frame_err", 32'(frame_err), 32'd0);
`ifdef UART_RX_PARITY_EN
    check_eq("reset_parity_err", 32'(parity_err), 32'd0);
`endif
    rst   = 1'b0;
    rx_en = 1'b1;
    repeat (5) @(negedge clk);
    hold_en = 1'b1;

    // Single clean frame and its latency from the falling edge of rx.
    base = n_done;
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check_eq("a5_done_count", 32'(n_done - base), 32'd1);
    check_eq("a5_latency_in_range", 32'(last_lat >= 153 && last_lat <= 155), 32'd1);
    check_eq("a5_data_held", 32'(data), 32'hA5);
    check_eq("a5_busy_after", 32'(busy), 32'd0);

    // Framing error, then line held low: no retrigger until it rises again.
    base = n_done;
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check_eq("ferr_done_count", 32'(n_done - base), 32'd1);
    check_eq("ferr_flag_held", 32'(frame_err), 32'd1);
    check_eq("ferr_data_held", 32'(data), 32'h3C);
    idle_cycles(CPB);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check_eq("after_ferr_done_count", 32'(n_done - base), 32'd2);
    check_eq("after_ferr_flag_clear", 32'(frame_err), 32'd0);

    // Short low glitch while idle.
    base = n_done;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("glitch_busy_low", 32'(busy), 32'd0);
    idle_cycles(200);
    check_eq("glitch_no_done", 32'(n_done - base), 32'd0);

    // Back-to-back frames with no idle gap.
    base = n_done;
    send_frame(8'h01, 1'b1, ^8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check_eq("b2b_done_count", 32'(n_done - base), 32'd2);
    check_eq("b2b_last_data", 32'(data), 32'hFF);

    // Receiver disabled: a full frame must be ignored.
    base  = n_done;
    rx_en = 1'b0;
    send_frame(8'h99, 1'b1, ^8'h99, 1'b0, 1'b0);
    idle_cycles(2 * CPB);
    rx_en = 1'b1;
    check_eq("disabled_no_done", 32'(n_done - base), 32'd0);

    // Reset during bit 4 of 0x55 aborts the frame; 0x81 follows normally.
    base    = n_done;
    hold_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midreset_busy", 32'(busy), 32'd0);
    check_eq("midreset_data", 32'(data), 32'd0);
    rst = 1'b0;
    idle_cycles(12 * CPB);
    hold_en = 1'b1;
    check_eq("midreset_no_done", 32'(n_done - base), 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check_eq("after_reset_done_count", 32'(n_done - base), 32'd1);
    check_eq("after_reset_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check_eq("par_good_flag", 32'(parity_err), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check_eq("par_bad_flag", 32'(parity_err), 32'd1);
    check_eq("par_bad_data", 32'(data), 32'h07);
`endif

    // Random frames: random data, stop bit, parity, gaps, and rx_en dropped
    // mid-frame (which must not abort reception).
    for (int n = 0; n < 40; n++) begin
      d      = DW'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop_b, par_b, bit'($urandom_range(0, 1)), 1'b1);
      if (!stop_b) idle_cycles(CPB + int'($urandom_range(0, CPB)));
      else if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(1, 2 * CPB)));
    end
    idle_cycles(2 * CPB);

    waited = 0;
    while (exp_q.size() != 0 && waited < 40 * CPB) begin
      @(negedge clk);
      waited++;
    end
    check_eq("all_frames_received", 32'(exp_q.size()), 32'd0);
    check_eq("hold_and_pulse_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
